// File: rtl/pulse_request_scheduler.sv
// pulse_request_scheduler: turns rising edges on front-panel button levels into latched
// requests and serialises them round-robin onto a shared datapath as one-cycle one-hot
// pulses, honouring Ready and a fixed holdoff gap after every grant.
// Optional feature: define PRS_DROP_COUNT_EN to build the saturating DropCount counter;
// otherwise DropCount is tied to zero and dropped presses are discarded silently.
module pulse_request_scheduler #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned HOLDOFF = 3
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [NUM_REQ-1:0]         DataIn,
   input  logic                       Ready,
   output logic [NUM_REQ-1:0]         DataOut,
   output logic [$clog2(NUM_REQ)-1:0] GrantId,
   output logic [NUM_REQ-1:0]         Pending,
   output logic                       Busy,
   output logic [7:0]                 DropCount
);

   localparam int unsigned IdW = $clog2(NUM_REQ);
   localparam logic [IdW-1:0] LastId = IdW'(NUM_REQ - 1);
   // HOLD is left when the counter reads zero, so it is loaded with HOLDOFF-1.
   localparam logic [3:0] HoldInit = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

   typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

   state_e             state_q, state_d;
   logic [3:0]         hold_cnt_q, hold_cnt_d;
   logic [NUM_REQ-1:0] prev_q;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [NUM_REQ-1:0] dataout_q, dataout_d;
   logic [IdW-1:0]     grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0] edge_det;
   logic [NUM_REQ-1:0] clear_mask;
   logic               sel_found;
   logic [IdW-1:0]     sel_idx;
   logic [IdW:0]       cand;

   assign edge_det = DataIn & ~prev_q;

   // Round-robin search: first pending channel starting just after the last grant.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int off = 1; off <= int'(NUM_REQ); off++) begin
         cand = {1'b0, grant_id_q} + (IdW+1)'(off);
         if (cand >= (IdW+1)'(NUM_REQ)) begin
            cand = cand - (IdW+1)'(NUM_REQ);
         end
         if (!sel_found && pending_q[cand[IdW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IdW-1:0];
         end
      end
   end

   // FSM next state, grant pulse, grant index and pending-clear mask.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      dataout_d  = '0;
      grant_id_d = grant_id_q;
      clear_mask = '0;
      unique case (state_q)
         StIdle: begin
            if (sel_found && Ready) begin
               state_d             = StGrant;
               dataout_d[sel_idx]  = 1'b1;
               grant_id_d          = sel_idx;
               clear_mask[sel_idx] = 1'b1;
            end
         end
         StGrant: begin
            if (HOLDOFF > 0) begin
               state_d    = StHold;
               hold_cnt_d = HoldInit;
            end else begin
               state_d = StIdle;
            end
         end
         StHold: begin
            if (hold_cnt_q == 4'd0) begin
               state_d = StIdle;
            end else begin
               hold_cnt_d = hold_cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A fresh edge on the channel being served re-arms it rather than counting as a drop.
   always_comb begin
      pending_d = (pending_q & ~clear_mask) | edge_det;
   end

   // State, request and output registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= StIdle;
         hold_cnt_q <= 4'd0;
         prev_q     <= '1;
         pending_q  <= '0;
         dataout_q  <= '0;
         grant_id_q <= LastId;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         prev_q     <= DataIn;
         pending_q  <= pending_d;
         dataout_q  <= dataout_d;
         grant_id_q <= grant_id_d;
      end
   end

`ifdef PRS_DROP_COUNT_EN
   logic       drop_hit;
   logic [7:0] drop_cnt_q;

   assign drop_hit = |(edge_det & pending_q & ~clear_mask);

   // Saturating drop counter; simultaneous drops on several channels count once.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         drop_cnt_q <= 8'd0;
      end else if (drop_hit && (drop_cnt_q != 8'hff)) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign DropCount = drop_cnt_q;
`else
   assign DropCount = 8'd0;
`endif

   assign DataOut = dataout_q;
   assign GrantId = grant_id_q;
   assign Pending = pending_q;
   assign Busy    = (state_q != StIdle);

endmodule

// File: tb/tb_pulse_request_scheduler.sv
// Bench for pulse_request_scheduler: a constant vector table for the basic grant/holdoff
// flow, hand sequences for Ready, drop, reset-hold and reset-abort corners, then random
// stimulus compared every cycle against a transaction-level reference model.
module tb_pulse_request_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned HO = 3;
`ifdef PRS_DROP_COUNT_EN
   localparam bit DropEn = 1'b1;
`else
   localparam bit DropEn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         rdy;
   logic [N-1:0] din;
   logic [N-1:0] dout;
   logic [N-1:0] pend;
   logic [1:0]   gid;
   logic         busy;
   logic [7:0]   dcnt;

   always #5 clk = ~clk;

   pulse_request_scheduler #(
      .NUM_REQ (N),
      .HOLDOFF (HO)
   ) dut (
      .Clk       (clk),
      .Reset     (rst),
      .DataIn    (din),
      .Ready     (rdy),
      .DataOut   (dout),
      .GrantId   (gid),
      .Pending   (pend),
      .Busy      (busy),
      .DropCount (dcnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: busy_left counts remaining GRANT+HOLD cycles after a grant.
   logic [N-1:0] m_prev;
   logic [N-1:0] m_pend;
   logic [N-1:0] m_out;
   int           m_gid;
   int           m_drop;
   int           m_busy_left;

   typedef struct {
      logic         rst;
      logic [N-1:0] din;
      logic         rdy;
      logic [N-1:0] out;
      logic [N-1:0] pend;
      logic         busy;
      logic [1:0]   gid;
   } vec_t;

   vec_t vt[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int exp_drop();
      return DropEn ? m_drop : 0;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_prev      = '1;
         m_pend      = '0;
         m_out       = '0;
         m_gid       = N - 1;
         m_drop      = 0;
         m_busy_left = 0;
      end else begin
         logic [N-1:0] edges;
         logic [N-1:0] clr;
         int           sel;
         edges = din & ~m_prev;
         clr   = '0;
         m_out = '0;
         sel   = 0;
         if (m_busy_left == 0 && m_pend != 0 && rdy) begin
            for (int k = 1; k <= int'(N); k++) begin
               sel = (m_gid + k) % N;
               if (m_pend[sel]) break;
            end
            clr[sel]    = 1'b1;
            m_out[sel]  = 1'b1;
            m_gid       = sel;
            m_busy_left = 1 + HO;
         end else if (m_busy_left > 0) begin
            m_busy_left--;
         end
         if (((edges & m_pend & ~clr) != 0) && m_drop < 255) m_drop++;
         m_pend = (m_pend & ~clr) | edges;
         m_prev = din;
      end
   endtask

   // One clock: advance model with the applied inputs, then compare away from the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model_dataout", 32'(dout), 32'(m_out));
      chk("model_pending", 32'(pend), 32'(m_pend));
      chk("model_grantid", 32'(gid), 32'(m_gid));
      chk("model_busy", 32'(busy), 32'(m_busy_left != 0));
      chk("model_dropcount", 32'(dcnt), 32'(exp_drop()));
   endtask

   task automatic apply(input logic r, input logic [N-1:0] d, input logic y);
      rst = r;
      din = d;
      rdy = y;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      din = '0;
      rdy = 1'b1;

      // rst, din, rdy -> DataOut, Pending, Busy, GrantId
      vt[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3};
      vt[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3};
      vt[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, 2'd3};
      vt[3]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 2'd2};
      vt[4]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd2};
      vt[5]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd2};
      vt[6]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd2};
      vt[7]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2};
      vt[8]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2};
      vt[9]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3};
      vt[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3};
      vt[11] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b1001, 1'b0, 2'd3};
      vt[12] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 4'b1000, 1'b1, 2'd0};
      vt[13] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd0};
      vt[14] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd0};
      vt[15] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd0};
      vt[16] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b1000, 1'b0, 2'd0};
      vt[17] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 4'b0000, 1'b1, 2'd3};
      vt[18] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd3};
      vt[19] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd3};
      vt[20] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd3};
      vt[21] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3};

      for (int i = 0; i < 22; i++) begin
         apply(vt[i].rst, vt[i].din, vt[i].rdy);
         chk($sformatf("vec%0d_dataout", i), 32'(dout), 32'(vt[i].out));
         chk($sformatf("vec%0d_pending", i), 32'(pend), 32'(vt[i].pend));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
         chk($sformatf("vec%0d_grantid", i), 32'(gid), 32'(vt[i].gid));
      end

      // Ready low holds a pending request off indefinitely.
      apply(1'b1, 4'b0000, 1'b1);
      apply(1'b0, 4'b0000, 1'b1);
      apply(1'b0, 4'b0010, 1'b0);
      for (int i = 0; i < 10; i++) begin
         apply(1'b0, 4'b0000, 1'b0);
         chk("rdy_low_dataout", 32'(dout), 32'd0);
         chk("rdy_low_busy", 32'(busy), 32'd0);
         chk("rdy_low_pending", 32'(pend), 32'b0010);
      end
      apply(1'b0, 4'b0000, 1'b1);
      chk("rdy_rise_dataout", 32'(dout), 32'b0010);

      // Re-press while pending is a drop; a press on the channel being cleared is not.
      apply(1'b1, 4'b0000, 1'b0);
      apply(1'b0, 4'b0000, 1'b0);
      apply(1'b0, 4'b0010, 1'b0);
      apply(1'b0, 4'b0000, 1'b0);
      apply(1'b0, 4'b0010, 1'b0);
      chk("drop_count", 32'(dcnt), DropEn ? 32'd1 : 32'd0);
      chk("drop_pending", 32'(pend[1]), 32'd1);
      apply(1'b0, 4'b0000, 1'b0);
      apply(1'b0, 4'b0010, 1'b1);
      chk("rearm_dataout", 32'(dout), 32'b0010);
      chk("rearm_pending", 32'(pend), 32'b0010);
      chk("rearm_dropcount", 32'(dcnt), DropEn ? 32'd1 : 32'd0);

      // Button held through reset release must not fire.
      apply(1'b1, 4'b0001, 1'b1);
      apply(1'b1, 4'b0001, 1'b1);
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 4'b0001, 1'b1);
         chk("held_dataout", 32'(dout), 32'd0);
         chk("held_pending", 32'(pend), 32'd0);
      end
      apply(1'b0, 4'b0000, 1'b1);
      apply(1'b0, 4'b0001, 1'b1);
      chk("repress_pending", 32'(pend), 32'b0001);
      apply(1'b0, 4'b0001, 1'b1);
      chk("repress_dataout", 32'(dout), 32'b0001);

      // Reset during HOLD with Pending=0110 aborts everything.
      apply(1'b1, 4'b0000, 1'b1);
      apply(1'b0, 4'b0000, 1'b1);
      apply(1'b0, 4'b0111, 1'b0);
      apply(1'b0, 4'b0111, 1'b1);
      chk("abort_pre_pending", 32'(pend), 32'b0110);
      apply(1'b0, 4'b0111, 1'b1);
      chk("abort_hold_busy", 32'(busy), 32'd1);
      apply(1'b1, 4'b0111, 1'b1);
      chk("abort_pending", 32'(pend), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_dataout", 32'(dout), 32'd0);
      chk("abort_grantid", 32'(gid), 32'd3);
      apply(1'b0, 4'b0000, 1'b1);
      apply(1'b0, 4'b0001, 1'b1);
      apply(1'b0, 4'b0001, 1'b1);
      chk("abort_first_grant", 32'(dout), 32'b0001);
      chk("abort_first_gid", 32'(gid), 32'd0);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         logic [N-1:0] nd;
         nd = din;
         for (int b = 0; b < int'(N); b++) begin
            if ($urandom_range(0, 5) == 0) nd[b] = ~nd[b];
         end
         apply(($urandom_range(0, 99) == 0), nd, ($urandom_range(0, 3) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
